// File: rtl/cud_pkg.sv
// Shared types and constants for the up/down counter with load and wrap flag.
package cud_pkg;

  parameter int CUD_WIDTH = 4;

  typedef logic [CUD_WIDTH-1:0] cud_count_t;

  typedef enum logic {
    CUD_DOWN = 1'b0,
    CUD_UP   = 1'b1
  } cud_dir_e;

endpackage

// File: rtl/cud_if.sv
// Signal bundle for counter_up_down; the clock is the only interface port.
interface cud_if
  import cud_pkg::*;
(
  input logic clk
);

  logic       rstn;
  logic       load_en;
  cud_count_t load;
  logic       ud;
  cud_count_t count;
  logic       rollover;

  modport dut (
    input  clk,
    input  rstn,
    input  load_en,
    input  load,
    input  ud,
    output count,
    output rollover
  );

  modport tb (
    input  clk,
    output rstn,
    output load_en,
    output load,
    output ud,
    input  count,
    input  rollover
  );

endinterface

// File: rtl/counter_up_down.sv
// Modular up/down counter with parallel load; rollover pulses for the one
// cycle in which count shows a wrapped value.
module counter_up_down
  import cud_pkg::*;
#(
  parameter int WIDTH = CUD_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load,
  input  logic             ud,
  output logic [WIDTH-1:0] count,
  output logic             rollover
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_nxt;
  logic             rollover_nxt;

  // Load beats counting, so a load on a would-be wrap edge never flags.
  always_comb begin
    count_nxt    = count;
    rollover_nxt = 1'b0;
    if (load_en) begin
      count_nxt    = load;
      rollover_nxt = 1'b0;
    end else if (ud == CUD_UP) begin
      count_nxt    = count + ONE;
      rollover_nxt = (count == MAX_VAL);
    end else begin
      count_nxt    = count - ONE;
      rollover_nxt = (count == '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count    <= '0;
      rollover <= 1'b0;
    end else begin
      count    <= count_nxt;
      rollover <= rollover_nxt;
    end
  end

endmodule

// File: tb/tb_counter_up_down.sv
// Directed and randomized checks of counter_up_down against an integer
// reference model of the counting and wrap rules.
module tb_counter_up_down;
  import cud_pkg::*;

  localparam int MAX = (1 << CUD_WIDTH) - 1;

  logic clk;
  int   total;
  int   bad;
  int   m_count;
  logic m_roll;

  cud_if bus (.clk(clk));

  counter_up_down dut (
    .clk      (clk),
    .rstn     (bus.rstn),
    .load_en  (bus.load_en),
    .load     (bus.load),
    .ud       (bus.ud),
    .count    (bus.count),
    .rollover (bus.rollover)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // ---------------- reference model ----------------
  task automatic model_edge(input logic le, input int lv, input logic dir);
    int v;
    if (le) begin
      m_count = lv;
      m_roll  = 1'b0;
    end else begin
      v       = dir ? m_count + 1 : m_count - 1;
      m_roll  = (v > MAX) || (v < 0);
      m_count = (v + MAX + 1) % (MAX + 1);
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input int exp_c, input logic exp_r);
    cud_count_t ec;
    ec = cud_count_t'(exp_c);
    total++;
    assert (bus.count === ec && bus.rollover === exp_r)
    else begin
      bad++;
      $error("FAIL %s: count=%0d rollover=%b expected count=%0d rollover=%b",
             tag, bus.count, bus.rollover, ec, exp_r);
    end
  endtask

  // ---------------- driver ----------------
  // Call from just after a falling edge: drive, take one rising edge, check.
  task automatic tick(input string tag, input logic le, input int lv, input logic dir);
    bus.load_en = le;
    bus.load    = cud_count_t'(lv);
    bus.ud      = dir;
    @(posedge clk);
    model_edge(le, lv, dir);
    @(negedge clk);
    check(tag, m_count, m_roll);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    m_count = 0;
    m_roll  = 1'b0;
    bus.rstn    = 1'b0;
    bus.load_en = 1'b0;
    bus.load    = '0;
    bus.ud      = 1'b1;

    // Reset held for 25 ns across a rising edge at 10 ns.
    #5  check("reset_t5", 0, 1'b0);
    #10 check("reset_t15", 0, 1'b0);
    #9  check("reset_t24", 0, 1'b0);
    #1  bus.rstn = 1'b1;
    tick("first_edge_up", 1'b0, 0, 1'b1);
    check("first_edge_is_1", 1, 1'b0);

    // Load then count up through the wrap.
    tick("load5", 1'b1, 5, 1'b1);
    check("load5_const", 5, 1'b0);
    for (int i = 1; i <= 25; i++) begin
      tick($sformatf("up_%0d", i), 1'b0, 0, 1'b1);
      if (i == 10) check("up10_is_max", MAX, 1'b0);
      if (i == 11) check("up11_wrap", 0, 1'b1);
      if (i == 12) check("up12_after_wrap", 1, 1'b0);
    end
    check("up25_is_14", 14, 1'b0);

    // Down through zero.
    tick("load1", 1'b1, 1, 1'b0);
    tick("down_to0", 1'b0, 0, 1'b0);
    check("down_to0_const", 0, 1'b0);
    tick("down_wrap", 1'b0, 0, 1'b0);
    check("down_wrap_const", MAX, 1'b1);
    tick("down_to14", 1'b0, 0, 1'b0);
    check("down_to14_const", 14, 1'b0);

    // Load wins over wrap conditions.
    tick("load15", 1'b1, MAX, 1'b1);
    tick("load_over_upwrap", 1'b1, 9, 1'b1);
    check("load_over_upwrap_const", 9, 1'b0);
    tick("load0", 1'b1, 0, 1'b0);
    tick("load_over_downwrap", 1'b1, 0, 1'b0);
    check("load_over_downwrap_const", 0, 1'b0);
    tick("load0_then_down", 1'b0, 0, 1'b0);
    check("load0_then_down_const", MAX, 1'b1);

    // Inputs changed between edges must not matter.
    tick("load7", 1'b1, 7, 1'b1);
    bus.load_en = 1'b1;
    bus.load    = cud_count_t'(3);
    bus.ud      = 1'b0;
    #3 bus.load_en = 1'b0;
    bus.ud = 1'b1;
    #1 check("glitch_no_effect", 7, 1'b0);
    tick("after_glitch", 1'b0, 0, 1'b1);

    // Async reset mid-count, including while rollover is high.
    tick("load6", 1'b1, 6, 1'b1);
    tick("up_to7", 1'b0, 0, 1'b1);
    #2 bus.rstn = 1'b0;
    #1 check("async_reset_now", 0, 1'b0);
    m_count = 0;
    m_roll  = 1'b0;
    #3 bus.rstn = 1'b1;
    tick("post_reset_1", 1'b0, 0, 1'b1);
    check("post_reset_1_const", 1, 1'b0);
    tick("post_reset_2", 1'b0, 0, 1'b1);
    tick("post_reset_3", 1'b0, 0, 1'b1);
    check("post_reset_3_const", 3, 1'b0);
    tick("load15_b", 1'b1, MAX, 1'b1);
    tick("wrap_before_reset", 1'b0, 0, 1'b1);
    #2 bus.rstn = 1'b0;
    #1 check("async_reset_clears_roll", 0, 1'b0);
    m_count = 0;
    m_roll  = 1'b0;
    #3 bus.rstn = 1'b1;
    tick("resume_down", 1'b0, 0, 1'b0);

    // Randomized traffic; occasional loads biased toward the wrap values.
    for (int i = 0; i < 300; i++) begin
      logic le;
      int   lv;
      logic dir;
      le  = ($urandom_range(0, 7) == 0);
      lv  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? MAX : 0)
                                        : int'($urandom_range(0, MAX));
      dir = ($urandom_range(0, 3) != 0) ? bus.ud : ~bus.ud;
      tick("random", le, lv, dir);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: simulation did not complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
